// File: rtl/midi_synth_pkg.sv
`default_nettype none
// ============================================================================
// Module   : midi_synth_pkg
// Purpose  : Shared MIDI status/CC constants, allocator FSM encoding, event type
// Revision : 1.0 - initial release
// ============================================================================
package midi_synth_pkg;

    localparam logic [3:0] NOTE_OFF = 4'h8;
    localparam logic [3:0] NOTE_ON  = 4'h9;
    localparam logic [3:0] CTRL     = 4'hB;

    localparam int CC_ALL_SOUND_OFF = 120;
    localparam int CC_ALL_NOTES_OFF = 123;

    localparam int         STATE_W     = 2;
    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_scan   = 2'd1;
    localparam logic [1:0] c_st_commit = 2'd2;

    typedef enum logic [1:0] {
        EV_NONE     = 2'd0,
        EV_NOTE_ON  = 2'd1,
        EV_NOTE_OFF = 2'd2,
        EV_ALL_OFF  = 2'd3
    } event_t;

    // Note-On with velocity 0 is the running-status idiom for Note-Off.
    function automatic event_t classify(input logic [3:0] status,
                                        input logic       vel_zero,
                                        input logic       cc_all_off);
        classify = EV_NONE;
        case (status)
            NOTE_ON:  classify = vel_zero ? EV_NOTE_OFF : EV_NOTE_ON;
            NOTE_OFF: classify = EV_NOTE_OFF;
            CTRL:     if (cc_all_off) classify = EV_ALL_OFF;
            default:  classify = EV_NONE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/voice_age_tracker.sv
`default_nettype none
// ============================================================================
// Module   : voice_age_tracker
// Purpose  : LRU age permutation for the voice pool; 0 = most recent
// Revision : 1.0 - initial release
// ============================================================================
module voice_age_tracker #(
    parameter int NUM_VOICES = 4,
    parameter int IDX_W      = $clog2(NUM_VOICES)
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst_n,
    input  logic                        touch_en,
    input  logic [IDX_W-1:0]            touch_idx,
    output logic [NUM_VOICES*IDX_W-1:0] ages,
    output logic [IDX_W-1:0]            oldest_idx
);

    localparam logic [IDX_W-1:0] c_oldest_age = IDX_W'(NUM_VOICES - 1);

    logic [IDX_W-1:0] r_age [NUM_VOICES];
    logic [IDX_W-1:0] w_touch_age;

    assign w_touch_age = r_age[touch_idx];

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < NUM_VOICES; i++) r_age[i] <= IDX_W'(i);
        end else if (touch_en) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (IDX_W'(i) == touch_idx)
                    r_age[i] <= '0;
                else if (r_age[i] < w_touch_age)
                    r_age[i] <= r_age[i] + IDX_W'(1);
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_VOICES; g++) begin : g_age_pack
            assign ages[g*IDX_W +: IDX_W] = r_age[g];
        end
    endgenerate

    always_comb begin
        oldest_idx = '0;
        for (int i = 0; i < NUM_VOICES; i++)
            if (r_age[i] == c_oldest_age) oldest_idx = IDX_W'(i);
    end

endmodule
`default_nettype wire

// File: rtl/midi_voice_allocator.sv
`default_nettype none
// ============================================================================
// Module   : midi_voice_allocator
// Purpose  : Polyphonic free-first / oldest-steal voice allocator for MIDI
// Revision : 1.0 - initial release
// ============================================================================
module midi_voice_allocator
    import midi_synth_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int BYTE_W     = 8,
    parameter int MIDI_CH    = 0,
    parameter int OMNI       = 0
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic [BYTE_W-1:0]       MIDI_CMD,
    input  logic [BYTE_W-1:0]       MIDI_DAT_0,
    input  logic [BYTE_W-1:0]       MIDI_DAT_1,
    input  logic                    DATA_READY,
    output logic [NUM_VOICES-1:0]   voice_gate,
    output logic [7*NUM_VOICES-1:0] voice_note,
    output logic [7*NUM_VOICES-1:0] voice_vel,
    output logic [NUM_VOICES-1:0]   voice_trig,
    output logic                    busy,
    output logic                    overflow
);

    localparam int               IDX_W      = $clog2(NUM_VOICES);
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_VOICES - 1);

    // ---------------- message decode ----------------
    logic [3:0] w_status;
    logic [3:0] w_chan;
    logic       w_ch_ok;
    logic       w_vel_zero;
    logic       w_cc_all_off;
    event_t     w_event;
    logic       w_accept;
    logic       w_unused;

    assign w_status     = MIDI_CMD[BYTE_W-1 -: 4];
    assign w_chan       = MIDI_CMD[BYTE_W-5 -: 4];
    assign w_ch_ok      = (OMNI != 0) || (w_chan == 4'(MIDI_CH));
    assign w_vel_zero   = (MIDI_DAT_1[6:0] == 7'd0);
    assign w_cc_all_off = (MIDI_DAT_0 == BYTE_W'(CC_ALL_SOUND_OFF)) ||
                          (MIDI_DAT_0 == BYTE_W'(CC_ALL_NOTES_OFF));
    assign w_event      = w_ch_ok ? classify(w_status, w_vel_zero, w_cc_all_off) : EV_NONE;
    assign w_accept     = DATA_READY && (w_event != EV_NONE);
    assign w_unused     = ^MIDI_DAT_1[BYTE_W-1:7];

    // ---------------- state ----------------
    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_nxt;

    event_t           r_ev;
    logic [6:0]       r_note;
    logic [6:0]       r_vel;
    logic [IDX_W-1:0] r_idx;
    logic             r_match_vld;
    logic [IDX_W-1:0] r_match_idx;
    logic             r_free_vld;
    logic [IDX_W-1:0] r_free_idx;
    logic [IDX_W-1:0] r_oldest_idx;
    logic             r_overflow;

    logic [NUM_VOICES-1:0] r_gate;
    logic [NUM_VOICES-1:0] r_trig;
    logic [6:0]            r_vnote [NUM_VOICES];
    logic [6:0]            r_vvel  [NUM_VOICES];

    logic [NUM_VOICES*IDX_W-1:0] w_ages;
    logic [IDX_W-1:0]            w_age_arr [NUM_VOICES];
    logic [IDX_W-1:0]            w_oldest_idx;
    logic [IDX_W-1:0]            w_target;
    logic                        w_touch_en;

    generate
        for (genvar g = 0; g < NUM_VOICES; g++) begin : g_age_unpack
            assign w_age_arr[g] = w_ages[g*IDX_W +: IDX_W];
        end
    endgenerate

    assign w_target   = r_match_vld ? r_match_idx :
                        r_free_vld  ? r_free_idx  : r_oldest_idx;
    assign w_touch_en = (r_state == c_st_commit) && (r_ev == EV_NOTE_ON);

    voice_age_tracker #(
        .NUM_VOICES (NUM_VOICES),
        .IDX_W      (IDX_W)
    ) u_age_tracker (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .touch_en   (w_touch_en),
        .touch_idx  (w_target),
        .ages       (w_ages),
        .oldest_idx (w_oldest_idx)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_state <= c_st_idle;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:   if (w_accept) w_state_nxt = c_st_scan;
            c_st_scan:   if (r_idx == c_last_idx) w_state_nxt = c_st_commit;
            c_st_commit: w_state_nxt = c_st_idle;
            default:     w_state_nxt = c_st_idle;
        endcase
    end

    // ---------------- event latch and scan ----------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_ev         <= EV_NONE;
            r_note       <= '0;
            r_vel        <= '0;
            r_idx        <= '0;
            r_match_vld  <= 1'b0;
            r_match_idx  <= '0;
            r_free_vld   <= 1'b0;
            r_free_idx   <= '0;
            r_oldest_idx <= '0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_accept && (r_state != c_st_idle)) r_overflow <= 1'b1;
            case (r_state)
                c_st_idle: if (w_accept) begin
                    r_ev         <= w_event;
                    r_note       <= MIDI_DAT_0[6:0];
                    r_vel        <= MIDI_DAT_1[6:0];
                    r_idx        <= '0;
                    r_match_vld  <= 1'b0;
                    r_match_idx  <= '0;
                    r_free_vld   <= 1'b0;
                    r_free_idx   <= '0;
                    r_oldest_idx <= w_oldest_idx;
                end
                c_st_scan: begin
                    if (!r_match_vld && r_gate[r_idx] && (r_vnote[r_idx] == r_note)) begin
                        r_match_vld <= 1'b1;
                        r_match_idx <= r_idx;
                    end
                    if (!r_free_vld && !r_gate[r_idx]) begin
                        r_free_vld <= 1'b1;
                        r_free_idx <= r_idx;
                    end
                    if (w_age_arr[r_idx] == c_last_idx) r_oldest_idx <= r_idx;
                    if (r_idx != c_last_idx) r_idx <= r_idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    // ---------------- voice state, updated only in COMMIT ----------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_gate <= '0;
            r_trig <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_vnote[i] <= '0;
                r_vvel[i]  <= '0;
            end
        end else begin
            r_trig <= '0;
            if (r_state == c_st_commit) begin
                case (r_ev)
                    EV_NOTE_ON: begin
                        r_gate[w_target]  <= 1'b1;
                        r_vnote[w_target] <= r_note;
                        r_vvel[w_target]  <= r_vel;
                        r_trig[w_target]  <= 1'b1;
                    end
                    EV_NOTE_OFF: if (r_match_vld) r_gate[r_match_idx] <= 1'b0;
                    EV_ALL_OFF:  r_gate <= '0;
                    default: ;
                endcase
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice_pack
            assign voice_note[7*g +: 7] = r_vnote[g];
            assign voice_vel[7*g +: 7]  = r_vvel[g];
        end
    endgenerate

    assign voice_gate = r_gate;
    assign voice_trig = r_trig;
    assign busy       = (r_state != c_st_idle);
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_midi_voice_allocator.sv
`default_nettype none
// ============================================================================
// Module   : tb_midi_voice_allocator
// Purpose  : Directed self-checking bench for midi_voice_allocator (4 voices)
// Revision : 1.0 - initial release
// ============================================================================
module tb_midi_voice_allocator;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [7:0]  MIDI_CMD = '0;
    logic [7:0]  MIDI_DAT_0 = '0;
    logic [7:0]  MIDI_DAT_1 = '0;
    logic        DATA_READY = 1'b0;
    logic [3:0]  voice_gate;
    logic [27:0] voice_note;
    logic [27:0] voice_vel;
    logic [3:0]  voice_trig;
    logic        busy;
    logic        overflow;

    int          n_checks = 0;
    int          n_fails  = 0;
    int          busy_cnt;
    int          trig_cnt;
    int          trig_cyc;
    logic [3:0]  trig_seen;

    midi_voice_allocator #(
        .NUM_VOICES (4),
        .BYTE_W     (8),
        .MIDI_CH    (0),
        .OMNI       (0)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .MIDI_CMD   (MIDI_CMD),
        .MIDI_DAT_0 (MIDI_DAT_0),
        .MIDI_DAT_1 (MIDI_DAT_1),
        .DATA_READY (DATA_READY),
        .voice_gate (voice_gate),
        .voice_note (voice_note),
        .voice_vel  (voice_vel),
        .voice_trig (voice_trig),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge sys_clk); #1;
        sys_rst_n  = 1'b0;
        DATA_READY = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
    endtask

    // One-cycle DATA_READY, then observe an 8-cycle window (j = cycles after the strobe).
    task automatic send(input logic [7:0] cmd, input logic [7:0] d0, input logic [7:0] d1);
        @(posedge sys_clk); #1;
        MIDI_CMD   = cmd;
        MIDI_DAT_0 = d0;
        MIDI_DAT_1 = d1;
        DATA_READY = 1'b1;
        busy_cnt  = 0;
        trig_cnt  = 0;
        trig_cyc  = -1;
        trig_seen = '0;
        for (int j = 1; j <= 8; j++) begin
            @(posedge sys_clk); #1;
            DATA_READY = 1'b0;
            if (busy) busy_cnt++;
            if (voice_trig != 4'b0) begin
                trig_cnt  += $countones(voice_trig);
                trig_seen |= voice_trig;
                if (trig_cyc < 0) trig_cyc = j;
            end
        end
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_gate",     32'(voice_gate), 32'h0);
        check("rst_trig",     32'(voice_trig), 32'h0);
        check("rst_busy",     32'(busy),       32'h0);
        check("rst_overflow", 32'(overflow),   32'h0);
        check("rst_note",     32'(voice_note), 32'h0);
        check("rst_vel",      32'(voice_vel),  32'h0);

        // First Note-On lands on voice 0 with fixed latency
        send(8'h90, 8'd60, 8'd100);
        check("on1_gate",     32'(voice_gate),      32'h1);
        check("on1_note0",    32'(voice_note[6:0]), 32'd60);
        check("on1_vel0",     32'(voice_vel[6:0]),  32'd100);
        check("on1_trig_cnt", 32'(trig_cnt),        32'd1);
        check("on1_trig_bit", 32'(trig_seen),       32'h1);
        check("on1_trig_cyc", 32'(trig_cyc),        32'd6);
        check("on1_busy_cyc", 32'(busy_cnt),        32'd5);

        // Fill all voices, then steal the oldest (voice 0)
        do_reset();
        send(8'h90, 8'd60, 8'd100);
        send(8'h90, 8'd62, 8'd100);
        send(8'h90, 8'd64, 8'd100);
        send(8'h90, 8'd65, 8'd100);
        check("fill_gate",    32'(voice_gate), 32'hF);
        check("fill_notes",   32'(voice_note), 32'({7'd65, 7'd64, 7'd62, 7'd60}));
        send(8'h90, 8'd67, 8'd90);
        check("steal_trig",   32'(trig_seen),  32'h1);
        check("steal_tcnt",   32'(trig_cnt),   32'd1);
        check("steal_gate",   32'(voice_gate), 32'hF);
        check("steal_notes",  32'(voice_note), 32'({7'd65, 7'd64, 7'd62, 7'd67}));
        check("steal_vel0",   32'(voice_vel[6:0]), 32'd90);

        // Note-Off via velocity 0, then a redundant 0x80
        do_reset();
        send(8'h90, 8'd60, 8'd100);
        send(8'h90, 8'd60, 8'd0);
        check("off_gate",     32'(voice_gate),      32'h0);
        check("off_note0",    32'(voice_note[6:0]), 32'd60);
        check("off_vel0",     32'(voice_vel[6:0]),  32'd100);
        check("off_trig",     32'(trig_cnt),        32'd0);
        check("off_busy_cyc", 32'(busy_cnt),        32'd5);
        send(8'h80, 8'd60, 8'd64);
        check("off2_gate",    32'(voice_gate),      32'h0);
        check("off2_note0",   32'(voice_note[6:0]), 32'd60);
        check("off2_busy",    32'(busy_cnt),        32'd5);

        // All-Notes-Off, then allocation restarts at voice 0
        do_reset();
        send(8'h90, 8'd60, 8'd100);
        send(8'h90, 8'd62, 8'd100);
        check("ao_pre_gate",  32'(voice_gate), 32'h3);
        send(8'hB0, 8'd123, 8'd0);
        check("ao_gate",      32'(voice_gate), 32'h0);
        check("ao_trig",      32'(trig_cnt),   32'd0);
        check("ao_busy_cyc",  32'(busy_cnt),   32'd5);
        check("ao_notes",     32'(voice_note), 32'({7'd0, 7'd0, 7'd62, 7'd60}));
        send(8'h90, 8'd70, 8'd80);
        check("ao_next_gate", 32'(voice_gate),      32'h1);
        check("ao_next_trig", 32'(trig_seen),       32'h1);
        check("ao_next_note", 32'(voice_note[6:0]), 32'd70);
        send(8'hB0, 8'd120, 8'd0);
        check("aso_gate",     32'(voice_gate), 32'h0);

        // Channel filter and unrelated CC are ignored without busy
        do_reset();
        send(8'h91, 8'd60, 8'd100);
        check("ch_busy",      32'(busy_cnt),   32'd0);
        check("ch_gate",      32'(voice_gate), 32'h0);
        send(8'hB0, 8'd7, 8'd0);
        check("cc_busy",      32'(busy_cnt),   32'd0);
        check("cc_overflow",  32'(overflow),   32'h0);

        // Retrigger of a sounding note reuses its voice
        send(8'h90, 8'd60, 8'd100);
        send(8'h90, 8'd60, 8'd50);
        check("retrig_trig",  32'(trig_seen),       32'h1);
        check("retrig_gate",  32'(voice_gate),      32'h1);
        check("retrig_vel0",  32'(voice_vel[6:0]),  32'd50);

        // Event during busy is dropped; reset mid-SCAN aborts the pending event
        do_reset();
        @(posedge sys_clk); #1;
        MIDI_CMD = 8'h90; MIDI_DAT_0 = 8'd60; MIDI_DAT_1 = 8'd100;
        DATA_READY = 1'b1;
        @(posedge sys_clk); #1;
        DATA_READY = 1'b0;
        @(posedge sys_clk); #1;
        MIDI_DAT_0 = 8'd62;
        DATA_READY = 1'b1;
        @(posedge sys_clk); #1;
        DATA_READY = 1'b0;
        check("ovf_set",      32'(overflow), 32'h1);
        check("ovf_busy",     32'(busy),     32'h1);
        sys_rst_n = 1'b0;
        #1;
        check("abort_busy",   32'(busy),       32'h0);
        check("abort_ovf",    32'(overflow),   32'h0);
        check("abort_gate",   32'(voice_gate), 32'h0);
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        trig_cnt = 0;
        for (int j = 0; j < 8; j++) begin
            @(posedge sys_clk); #1;
            trig_cnt += $countones(voice_trig);
        end
        check("abort_trig",   32'(trig_cnt),   32'd0);
        check("abort_gate2",  32'(voice_gate), 32'h0);
        check("abort_note",   32'(voice_note), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/midi_voice_allocator.md
# midi_voice_allocator

Polyphonic voice allocator sitting directly downstream of the MIDI interface adapter. It consumes the adapter's command byte, data bytes and DATA_READY strobe; filters by channel; and maps Note-On, Note-Off and All-Notes-Off/All-Sound-Off events onto NUM_VOICES synth voices. Voices are assigned with a free-first, oldest-steal (LRU) policy. Each voice exposes gate, note, velocity and a trigger strobe to the oscillator/envelope bank.

## Interface
- NUM_VOICES, 4: voice count, 2..16.
- BYTE_W, 8: MIDI byte width.
- MIDI_CH, 0: accepted channel, 0..15.
- OMNI, 0: 1 = accept all channels.
- sys_clk  in  1  system clock; all logic on its rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- MIDI_CMD  in  BYTE_W  status byte from the adapter; sampled only in the DATA_READY cycle.
- MIDI_DAT_0  in  BYTE_W  first data byte (note number / CC number); sampled only in the DATA_READY cycle.
- MIDI_DAT_1  in  BYTE_W  second data byte (velocity / CC value); sampled only in the DATA_READY cycle.
- DATA_READY  in  1  one-cycle strobe: complete message present.
- voice_gate  out  NUM_VOICES  per-voice gate.
- voice_note  out  7*NUM_VOICES  packed note numbers; voice i occupies bits [7i+6:7i].
- voice_vel  out  7*NUM_VOICES  packed velocities, same packing.
- voice_trig  out  NUM_VOICES  one-cycle strobe when a voice is (re)assigned.
- busy  out  1  allocator is processing an event.
- overflow  out  1  sticky; an event was dropped.

## Operation
Message decode (MIDI_CMD upper nibble, lower nibble = channel):
- 0x9 with velocity > 0: Note-On.
- 0x8, or 0x9 with velocity 0: Note-Off.
- 0xB with MIDI_DAT_0 = 120 or 123: All-Off.
- Anything else, or a channel that does not match while OMNI = 0: ignored. busy is not raised.

FSM states are IDLE, SCAN and COMMIT.
- IDLE → SCAN: on an accepted DATA_READY.
  - Latch the type, note = DAT_0[6:0] and vel = DAT_1[6:0].
  - Clear the scan index and flags.
- SCAN: visit one voice per cycle, index 0 → NUM_VOICES-1. Record three results:
  - match_idx: first voice with gate = 1 and note equal to the latched note.
  - free_idx: lowest-index voice with gate = 0.
  - oldest_idx: the voice whose age = NUM_VOICES-1.
  - After the last index, go to COMMIT.
- COMMIT: apply the action below for the latched type, then return to IDLE.
  - Note-On, target voice chosen in priority order match_idx, then free_idx, then oldest_idx. On the target voice:
    - gate = 1;
    - note and vel loaded;
    - voice_trig bit pulsed;
    - LRU touched.
  - Note-Off with a match: gate = 0 on that voice. note, vel and age are retained.
  - Note-Off with no match: no change.
  - All-Off: all gates = 0; no trig; ages unchanged.
  - All-Off still runs the full SCAN, so latency is uniform.

LRU ages:
- Each voice holds an age of width clog2(NUM_VOICES); the ages always form a permutation of 0..NUM_VOICES-1.
- Touching voice v: every voice with age < age[v] increments, and age[v] becomes 0.

## Timing
- Reset values:
  - gate, trig, busy and overflow = 0;
  - all notes and velocities = 0;
  - age[i] = i;
  - FSM = IDLE.
- Reset asserted mid-SCAN or mid-COMMIT aborts the event; nothing is committed.
- Latency: DATA_READY in cycle t.
  - SCAN occupies cycles t+1..t+NUM_VOICES.
  - COMMIT occurs in cycle t+NUM_VOICES+1.
  - gate, note and vel are updated and voice_trig is high in cycle t+NUM_VOICES+2.
- busy is high for cycles t+1..t+NUM_VOICES+1.
- voice_trig is exactly one cycle wide.
- An accepted DATA_READY while busy = 1 is dropped and sets overflow. overflow stays 1 until reset.
- DATA_READY in the same cycle busy falls (FSM back in IDLE) is accepted.
- Stealing a gated voice:
  - gate stays 1 (no gap);
  - note/vel are replaced;
  - trig pulses.

## Structure
- Shared package midi_synth_pkg holds:
  - status nibbles (NOTE_OFF = 4'h8, NOTE_ON = 4'h9, CTRL = 4'hB);
  - CC_ALL_SOUND_OFF = 120 and CC_ALL_NOTES_OFF = 123;
  - FSM state encoding;
  - the event-type enum.
- One sub-module, voice_age_tracker, holds the LRU ages.
  - Inputs: touch_en and touch_idx.
  - Outputs: the age vector and oldest_idx.
- Scan and commit logic stay in the top module.

## Test plan
- Reset, then Note-On 0x90/60/100 → after 6 cycles (NUM_VOICES = 4):
  - voice 0 has gate = 1, note = 60, vel = 100;
  - trig[0] pulses once;
  - busy was high for 5 cycles.
- Note-On notes 60, 62, 64, 65, then 67 → 67 steals voice 0 (the oldest):
  - trig[0] pulses;
  - gates stay 4'b1111.
- Note-On 60, then 0x90/60/0 → gate[0] falls, note[0] remains 60; a second 0x80/60 produces no change.
- Note-On 60 on voices 0–1, then 0xB0/123/0 → gates = 0, and the next Note-On lands on voice 0.
- Channel filter (MIDI_CH = 0, OMNI = 0): 0x91/60/100 is ignored with busy never high.
  - Retrigger: Note-On 60 twice reuses voice 0 with a second trig.
- Second DATA_READY issued 2 cycles after the first → it is dropped and overflow = 1.
  - Assert sys_rst_n low mid-SCAN → all outputs return to reset values.
